// File: rtl/pea_fire_scheduler.sv
// Autonomous CFDF firing scheduler for the PEA actor: presents the current mode, waits for
// enable, strobes invoke, waits for firing completion, then adopts the requested next mode.
module pea_fire_scheduler #(
  parameter int TIMEOUT = 4000,
  parameter int TO_W    = 12,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             enable,
  input  logic             FC,
  input  logic [1:0]       next_mode_in,
  output logic             invoke,
  output logic [1:0]       next_instr,
  output logic             busy,
  output logic [CNT_W-1:0] fire_count,
  output logic             timeout_err,
  output logic             mode_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_CHECK, S_FIRE, S_WAIT, S_HALT
  } state_e;

  state_e           r_state;
  state_e           w_next_state;
  logic [TO_W-1:0]  r_wdog;
  logic             r_fc_armed;
  logic             r_invoke;
  logic             r_busy;
  logic [1:0]       r_next_instr;
  logic [CNT_W-1:0] r_fire_count;
  logic             r_timeout_err;
  logic             r_mode_err;
  logic             w_complete;
  logic             w_wdog_expire;
  logic             w_invoke_d;
  logic             w_busy_d;

  // A level FC still high from the previous firing must first be seen low before it counts.
  assign w_complete    = (r_state == S_WAIT) && FC && r_fc_armed;
  assign w_wdog_expire = (r_state == S_WAIT) && !w_complete &&
                         (r_wdog == TO_W'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next_state = S_SETTLE;
      S_SETTLE: w_next_state = S_CHECK;
      S_CHECK: begin
        if (!start)     w_next_state = S_IDLE;
        else if (enable) w_next_state = S_FIRE;
      end
      S_FIRE:   w_next_state = S_WAIT;
      S_WAIT: begin
        if (w_complete)         w_next_state = start ? S_SETTLE : S_IDLE;
        else if (w_wdog_expire) w_next_state = S_HALT;
      end
      S_HALT:   w_next_state = S_HALT;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they align with the state.
  always_comb begin
    w_invoke_d = 1'b0;
    w_busy_d   = 1'b0;
    case (w_next_state)
      S_SETTLE, S_CHECK, S_WAIT: w_busy_d = 1'b1;
      S_FIRE: begin
        w_busy_d   = 1'b1;
        w_invoke_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_invoke      <= 1'b0;
      r_busy        <= 1'b0;
      r_wdog        <= '0;
      r_fc_armed    <= 1'b0;
      r_next_instr  <= 2'b00;
      r_fire_count  <= '0;
      r_timeout_err <= 1'b0;
      r_mode_err    <= 1'b0;
    end else begin
      r_invoke <= w_invoke_d;
      r_busy   <= w_busy_d;
      case (r_state)
        S_FIRE: begin
          r_wdog     <= '0;
          r_fc_armed <= ~FC;
        end
        S_WAIT: begin
          if (!FC) r_fc_armed <= 1'b1;
          if (w_complete) begin
            r_fire_count <= r_fire_count + CNT_W'(1);
            if (next_mode_in == 2'b11) begin
              r_next_instr <= 2'b00;
              r_mode_err   <= 1'b1;
            end else begin
              r_next_instr <= next_mode_in;
            end
          end else begin
            r_wdog <= r_wdog + TO_W'(1);
            if (w_wdog_expire) r_timeout_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign invoke      = r_invoke;
  assign busy        = r_busy;
  assign next_instr  = r_next_instr;
  assign fire_count  = r_fire_count;
  assign timeout_err = r_timeout_err;
  assign mode_err    = r_mode_err;

endmodule

// File: tb/tb_pea_fire_scheduler.sv
// Self-checking bench for pea_fire_scheduler: a cycle-level behavioural model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_pea_fire_scheduler;

  localparam int TIMEOUT = 16;
  localparam int TO_W    = 12;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start = 1'b0;
  logic             enable = 1'b1;
  logic             FC = 1'b0;
  logic [1:0]       next_mode_in = 2'b00;
  logic             invoke;
  logic [1:0]       next_instr;
  logic             busy;
  logic [CNT_W-1:0] fire_count;
  logic             timeout_err;
  logic             mode_err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_inv    = 0;
  bit cmp_en   = 1'b0;

  pea_fire_scheduler #(.TIMEOUT(TIMEOUT), .TO_W(TO_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .enable(enable), .FC(FC),
    .next_mode_in(next_mode_in), .invoke(invoke), .next_instr(next_instr), .busy(busy),
    .fire_count(fire_count), .timeout_err(timeout_err), .mode_err(mode_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: "active" = run requested and awaiting a firing slot, "settle" = one-cycle
  // grace before enable is trusted, "flight" = firing issued and not yet complete.
  typedef struct packed {
    logic        active;
    logic        settle;
    logic        flight;
    logic        inv;
    logic        armed;
    logic        halt;
    logic        to;
    logic        me;
    logic [31:0] waitn;
    logic [1:0]  mode;
    logic [15:0] cnt;
  } model_t;

  model_t m;

  function automatic model_t step(model_t s, logic st, logic en, logic fc, logic [1:0] nm);
    model_t n = s;
    if (s.halt) return n;
    if (s.flight) begin
      if (s.inv) begin
        n.inv   = 1'b0;
        n.armed = !fc;
        n.waitn = 0;
      end else if (fc && s.armed) begin
        n.cnt = s.cnt + 16'd1;
        if (nm == 2'b11) begin
          n.mode = 2'b00;
          n.me   = 1'b1;
        end else begin
          n.mode = nm;
        end
        n.flight = 1'b0;
        n.active = st;
        n.settle = st;
      end else begin
        if (!fc) n.armed = 1'b1;
        n.waitn = s.waitn + 1;
        if (n.waitn == TIMEOUT) begin
          n.halt   = 1'b1;
          n.to     = 1'b1;
          n.flight = 1'b0;
          n.active = 1'b0;
        end
      end
    end else if (!s.active) begin
      if (st) begin
        n.active = 1'b1;
        n.settle = 1'b1;
      end
    end else if (s.settle) begin
      n.settle = 1'b0;
    end else if (!st) begin
      n.active = 1'b0;
    end else if (en) begin
      n.flight = 1'b1;
      n.inv    = 1'b1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= '0;
    else      m <= step(m, start, enable, FC, next_mode_in);
  end

  always @(negedge clk) begin
    if (invoke === 1'b1) n_inv++;
    if (cmp_en) begin
      check("cmp_invoke", {31'd0, invoke}, {31'd0, m.inv});
      check("cmp_next_instr", {30'd0, next_instr}, {30'd0, m.mode});
      check("cmp_busy", {31'd0, busy}, {31'd0, (m.active | m.flight)});
      check("cmp_fire_count", {16'd0, fire_count}, {16'd0, m.cnt});
      check("cmp_timeout_err", {31'd0, timeout_err}, {31'd0, m.to});
      check("cmp_mode_err", {31'd0, mode_err}, {31'd0, m.me});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    start = 1'b0; enable = 1'b1; FC = 1'b0; next_mode_in = 2'b00;
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
  endtask

  task automatic wait_invoke(input int budget, input string name);
    int k = 0;
    while (invoke !== 1'b1 && k < budget) begin
      tick(1);
      k++;
    end
    check(name, {31'd0, invoke}, 32'd1);
  endtask

  initial begin : global_guard
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin : stim
    int base;
    logic [1:0] modes [3];
    modes[0] = 2'b01; modes[1] = 2'b10; modes[2] = 2'b00;

    rst = 1'b1;
    #1 rst = 1'b0;
    cmp_en = 1'b1;
    tick(2);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_next_instr", {30'd0, next_instr}, 32'd0);
    rst = 1'b1;
    tick(1);

    // 1: single firing, FC pulse 5 cycles after invoke
    do_reset();
    base = n_inv;
    next_mode_in = 2'b01;
    start = 1'b1;
    tick(3);
    check("t1_invoke_cycle3", {31'd0, invoke}, 32'd1);
    check("t1_model_inv", {31'd0, m.inv}, 32'd1);
    tick(1);
    check("t1_invoke_one_cycle", {31'd0, invoke}, 32'd0);
    tick(4);
    FC = 1'b1;
    tick(1);
    FC = 1'b0;
    check("t1_fire_count", {16'd0, fire_count}, 32'd1);
    check("t1_next_instr", {30'd0, next_instr}, 32'd1);
    check("t1_busy_settle", {31'd0, busy}, 32'd1);
    start = 1'b0;
    tick(3);
    check("t1_busy_idle", {31'd0, busy}, 32'd0);
    check("t1_invoke_count", n_inv - base, 32'd1);

    // 2: three firings cycling through modes
    do_reset();
    base = n_inv;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_invoke(10, "t2_invoke");
      tick(2);
      next_mode_in = modes[i];
      FC = 1'b1;
      if (i == 2) start = 1'b0;
      tick(1);
      FC = 1'b0;
      check("t2_next_instr", {30'd0, next_instr}, {30'd0, modes[i]});
      check("t2_fire_count", {16'd0, fire_count}, i + 1);
    end
    tick(4);
    check("t2_busy_idle", {31'd0, busy}, 32'd0);
    check("t2_invoke_count", n_inv - base, 32'd3);

    // 3: enable low stalls in CHECK
    do_reset();
    enable = 1'b0;
    start = 1'b1;
    tick(3);
    base = n_inv;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("t3_stall_busy", {31'd0, busy}, 32'd1);
      check("t3_stall_no_invoke", {31'd0, invoke}, 32'd0);
    end
    enable = 1'b1;
    tick(1);
    check("t3_invoke_after_enable", {31'd0, invoke}, 32'd1);
    tick(1);
    FC = 1'b1;
    start = 1'b0;
    tick(1);
    FC = 1'b0;
    check("t3_fire_count", {16'd0, fire_count}, 32'd1);
    tick(3);
    check("t3_invoke_count", n_inv - base, 32'd1);

    // 4: stale level FC ignored; completion only on the fresh rise
    do_reset();
    base = n_inv;
    FC = 1'b1;
    start = 1'b1;
    wait_invoke(10, "t4_invoke");
    tick(2);
    FC = 1'b0;
    start = 1'b0;
    check("t4_stale_fc_ignored", {16'd0, fire_count}, 32'd0);
    tick(4);
    check("t4_no_completion_low", {16'd0, fire_count}, 32'd0);
    check("t4_busy_wait", {31'd0, busy}, 32'd1);
    FC = 1'b1;
    tick(1);
    check("t4_completion_on_rise", {16'd0, fire_count}, 32'd1);
    check("t4_busy_idle", {31'd0, busy}, 32'd0);
    tick(5);
    check("t4_invoke_count", n_inv - base, 32'd1);
    check("t4_fire_count_held", {16'd0, fire_count}, 32'd1);
    FC = 1'b0;

    // 5a: watchdog trips after TIMEOUT wait cycles
    do_reset();
    start = 1'b1;
    wait_invoke(10, "t5_invoke");
    base = n_inv;
    tick(16);
    check("t5_no_timeout_yet", {31'd0, timeout_err}, 32'd0);
    check("t5_busy_before_trip", {31'd0, busy}, 32'd1);
    tick(1);
    check("t5_timeout_err", {31'd0, timeout_err}, 32'd1);
    check("t5_halt_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      FC = ~FC;
      tick(1);
      check("t5_halt_no_invoke", {31'd0, invoke}, 32'd0);
    end
    check("t5_halt_invoke_count", n_inv - base, 32'd1);
    check("t5_timeout_sticky", {31'd0, timeout_err}, 32'd1);
    FC = 1'b0;

    // 5b: illegal mode request
    do_reset();
    start = 1'b1;
    wait_invoke(10, "t5b_invoke1");
    tick(2);
    next_mode_in = 2'b10;
    FC = 1'b1;
    tick(1);
    FC = 1'b0;
    check("t5b_next_instr_10", {30'd0, next_instr}, 32'd2);
    check("t5b_no_mode_err", {31'd0, mode_err}, 32'd0);
    wait_invoke(10, "t5b_invoke2");
    tick(2);
    next_mode_in = 2'b11;
    FC = 1'b1;
    start = 1'b0;
    tick(1);
    FC = 1'b0;
    check("t5b_mode_err", {31'd0, mode_err}, 32'd1);
    check("t5b_next_instr_00", {30'd0, next_instr}, 32'd0);
    check("t5b_fire_count", {16'd0, fire_count}, 32'd2);

    // 6: asynchronous reset mid-WAIT, then resume
    do_reset();
    start = 1'b1;
    next_mode_in = 2'b10;
    wait_invoke(10, "t6_invoke1");
    tick(2);
    FC = 1'b1;
    tick(1);
    FC = 1'b0;
    check("t6_pre_next_instr", {30'd0, next_instr}, 32'd2);
    wait_invoke(10, "t6_invoke2");
    tick(2);
    #1 rst = 1'b0;
    #1;
    check("t6_rst_invoke", {31'd0, invoke}, 32'd0);
    check("t6_rst_next_instr", {30'd0, next_instr}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_fire_count", {16'd0, fire_count}, 32'd0);
    check("t6_rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    check("t6_rst_mode_err", {31'd0, mode_err}, 32'd0);
    tick(1);
    rst = 1'b1;
    next_mode_in = 2'b01;
    tick(1);
    wait_invoke(10, "t6_resume_invoke");
    check("t6_resume_mode", {30'd0, next_instr}, 32'd0);
    tick(2);
    FC = 1'b1;
    start = 1'b0;
    tick(1);
    FC = 1'b0;
    check("t6_resume_next_instr", {30'd0, next_instr}, 32'd1);
    check("t6_resume_fire_count", {16'd0, fire_count}, 32'd1);

    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
